markov_table_ctrl: RTL and testbench

- Controller and arbiter for the shared Markov transition-count table used by the learning engine.
- Serialises two requesters onto one single-port synchronous RAM:
  - Training: read-modify-write increment of count[prev][cur].
  - Prediction: scans row prev and returns the most frequent next symbol.
- Sits between the learning/prediction FSMs and the table RAM, and owns all RAM access.

---
 rtl/markov_pkg.sv | 37 +++
 rtl/markov_rr_arb.sv | 58 +++++
 rtl/markov_table_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_markov_table_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/markov_pkg.sv
// ============================================================================
// markov_pkg: shared types and helpers for the Markov transition-count table.
// Optional MARKOV_CLEAR_EN adds the CLR state. Revision: 1.0
// ============================================================================
`default_nettype none

package markov_pkg;

  localparam int SYM_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TRN_RD   = 3'd1,
    TRN_WR   = 3'd2,
    PRD_SCAN = 3'd3,
    PRD_LAST = 3'd4,
    PRD_OUT  = 3'd5
`ifdef MARKOV_CLEAR_EN
    ,
    CLR      = 3'd6
`endif
  } state_e;

  typedef enum logic {
    TRAIN = 1'b0,
    PRED  = 1'b1
  } grant_e;

  // Saturating increment; callers truncate back to their own count width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/markov_rr_arb.sv
// ============================================================================
// markov_rr_arb: two-way round-robin grant between training and prediction.
// Revision: 1.0
// ============================================================================
`default_nettype none

module markov_rr_arb
  import markov_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_train,
  input  logic req_pred,
  input  logic accept,
  output logic gnt_train,
  output logic gnt_pred
);

  grant_e last_grant_q, last_grant_d;

  always_comb begin
    gnt_train = 1'b0;
    gnt_pred  = 1'b0;
    if (en) begin
      if (req_train && req_pred) begin
        // Contention goes to whichever side did not win last time.
        gnt_train = (last_grant_q == PRED);
        gnt_pred  = (last_grant_q == TRAIN);
      end else begin
        gnt_train = req_train;
        gnt_pred  = req_pred;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      if (gnt_train) begin
        last_grant_d = TRAIN;
      end else if (gnt_pred) begin
        last_grant_d = PRED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= PRED;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/markov_table_ctrl.sv
// ============================================================================
// markov_table_ctrl: arbitrates training increments and prediction row scans
// onto one single-port table RAM. Optional MARKOV_CLEAR_EN adds a table clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module markov_table_ctrl
  import markov_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 train_valid,
  output logic                 train_ready,
  input  logic [SYM_W-1:0]     train_prev,
  input  logic [SYM_W-1:0]     train_cur,
  output logic                 train_done,
  input  logic                 pred_req,
  output logic                 pred_ack,
  input  logic [SYM_W-1:0]     pred_prev,
  output logic                 pred_valid,
  input  logic                 pred_ready,
  output logic [SYM_W-1:0]     pred_sym,
  output logic [CNT_W-1:0]     pred_cnt,
  output logic                 pred_hit,
  output logic [2*SYM_W-1:0]   mem_addr,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [CNT_W-1:0]     mem_wdata,
  input  logic [CNT_W-1:0]     mem_rdata,
`ifdef MARKOV_CLEAR_EN
  input  logic                 clear_req,
  output logic                 clear_done,
`endif
  output logic                 busy
);

  localparam int               NSYM     = 1 << SYM_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SYM_W-1:0] SYM_ONE  = SYM_W'(1);
  localparam logic [SYM_W:0]   SCAN_ONE = (SYM_W+1)'(1);
  localparam logic [SYM_W:0]   SCAN_END = (SYM_W+1)'(NSYM);
`ifdef MARKOV_CLEAR_EN
  localparam logic [2*SYM_W-1:0] ADDR_ONE = (2*SYM_W)'(1);
  localparam logic [2*SYM_W-1:0] ADDR_MAX = '1;
`endif

  state_e           state_q, state_d;
  logic [SYM_W-1:0] prev_q, prev_d;
  logic [SYM_W-1:0] cur_q, cur_d;
  logic [SYM_W-1:0] best_sym_q, best_sym_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [SYM_W:0]   scan_q, scan_d;
`ifdef MARKOV_CLEAR_EN
  logic [2*SYM_W-1:0] clr_addr_q, clr_addr_d;
`endif

  logic             arb_en;
  logic             gnt_train;
  logic             gnt_pred;
  logic [CNT_W-1:0] inc_val;
  logic [SYM_W-1:0] cmp_sym;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    arb_en = (state_q == IDLE) && reset;
`ifdef MARKOV_CLEAR_EN
    arb_en = arb_en && !clear_req;
`endif
  end

  markov_rr_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (arb_en),
    .req_train (train_valid),
    .req_pred  (pred_req),
    .accept    (gnt_train | gnt_pred),
    .gnt_train (gnt_train),
    .gnt_pred  (gnt_pred)
  );

  assign inc_val     = CNT_W'(sat_inc(32'(mem_rdata), 32'(CNT_MAX)));
  // Read data always belongs to the previous scan index; in PRD_LAST the
  // low bits have wrapped to 0, so this yields NSYM-1.
  assign cmp_sym     = scan_q[SYM_W-1:0] - SYM_ONE;

  assign train_ready = gnt_train;
  assign pred_ack    = gnt_pred;
  assign pred_sym    = best_sym_q;
  assign pred_cnt    = best_cnt_q;
  assign pred_hit    = |best_cnt_q;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    best_sym_d = best_sym_q;
    best_cnt_d = best_cnt_q;
    scan_d     = scan_q;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    train_done = 1'b0;
    pred_valid = 1'b0;
`ifdef MARKOV_CLEAR_EN
    clr_addr_d = clr_addr_q;
    clear_done = 1'b0;
`endif

    case (state_q)
      IDLE: begin
`ifdef MARKOV_CLEAR_EN
        if (reset && clear_req) begin
          state_d    = CLR;
          clr_addr_d = '0;
        end else
`endif
        if (gnt_train) begin
          state_d = TRN_RD;
          prev_d  = train_prev;
          cur_d   = train_cur;
        end else if (gnt_pred) begin
          state_d    = PRD_SCAN;
          prev_d     = pred_prev;
          scan_d     = '0;
          best_sym_d = '0;
          best_cnt_d = '0;
        end
      end

      TRN_RD: begin
        mem_addr = {prev_q, cur_q};
        mem_re   = 1'b1;
        state_d  = TRN_WR;
      end

      TRN_WR: begin
        mem_addr   = {prev_q, cur_q};
        mem_we     = 1'b1;
        mem_wdata  = inc_val;
        train_done = 1'b1;
        state_d    = IDLE;
      end

      PRD_SCAN: begin
        mem_addr = {prev_q, scan_q[SYM_W-1:0]};
        mem_re   = 1'b1;
        // Strict greater-than keeps the lowest symbol on ties.
        if ((scan_q != '0) && (mem_rdata > best_cnt_q)) begin
          best_cnt_d = mem_rdata;
          best_sym_d = cmp_sym;
        end
        scan_d = scan_q + SCAN_ONE;
        if (scan_d == SCAN_END) begin
          state_d = PRD_LAST;
        end
      end

      PRD_LAST: begin
        if (mem_rdata > best_cnt_q) begin
          best_cnt_d = mem_rdata;
          best_sym_d = cmp_sym;
        end
        state_d = PRD_OUT;
      end

      PRD_OUT: begin
        pred_valid = 1'b1;
        if (pred_ready) begin
          state_d = IDLE;
        end
      end

`ifdef MARKOV_CLEAR_EN
      CLR: begin
        mem_addr = clr_addr_q;
        mem_we   = 1'b1;
        if (clr_addr_q == ADDR_MAX) begin
          clear_done = 1'b1;
          state_d    = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_ONE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      cur_q      <= '0;
      best_sym_q <= '0;
      best_cnt_q <= '0;
      scan_q     <= '0;
`ifdef MARKOV_CLEAR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      best_sym_q <= best_sym_d;
      best_cnt_q <= best_cnt_d;
      scan_q     <= scan_d;
`ifdef MARKOV_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_markov_table_ctrl.sv
// ============================================================================
// tb_markov_table_ctrl: directed bench for markov_table_ctrl with a RAM model.
// Clear sequence exercised only when MARKOV_CLEAR_EN is defined. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_markov_table_ctrl;

  localparam int SYM_W = 4;
  localparam int CNT_W = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               train_valid, train_ready, train_done;
  logic [SYM_W-1:0]   train_prev, train_cur;
  logic               pred_req, pred_ack, pred_valid, pred_ready, pred_hit;
  logic [SYM_W-1:0]   pred_prev, pred_sym;
  logic [CNT_W-1:0]   pred_cnt;
  logic [2*SYM_W-1:0] mem_addr;
  logic               mem_re, mem_we, busy;
  logic [CNT_W-1:0]   mem_wdata;
  logic [CNT_W-1:0]   mem_rdata = '0;
`ifdef MARKOV_CLEAR_EN
  logic               clear_req, clear_done;
`endif

  logic [CNT_W-1:0] ram [256];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  markov_table_ctrl #(.SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .train_valid (train_valid),
    .train_ready (train_ready),
    .train_prev  (train_prev),
    .train_cur   (train_cur),
    .train_done  (train_done),
    .pred_req    (pred_req),
    .pred_ack    (pred_ack),
    .pred_prev   (pred_prev),
    .pred_valid  (pred_valid),
    .pred_ready  (pred_ready),
    .pred_sym    (pred_sym),
    .pred_cnt    (pred_cnt),
    .pred_hit    (pred_hit),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
`ifdef MARKOV_CLEAR_EN
    .clear_req   (clear_req),
    .clear_done  (clear_done),
`endif
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    step();
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic do_train(input string tag, input logic [3:0] p, input logic [3:0] c,
                          input logic [7:0] exp_w);
    train_prev = p; train_cur = c; train_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, train_ready, 1);
    step();
    train_valid = 1'b0;
    chk({tag, "_rd_re"}, mem_re, 1);
    chk({tag, "_rd_addr"}, mem_addr, {p, c});
    step();
    chk({tag, "_wr_we"}, mem_we, 1);
    chk({tag, "_wr_addr"}, mem_addr, {p, c});
    chk({tag, "_wdata"}, mem_wdata, exp_w);
    chk({tag, "_done"}, train_done, 1);
    step();
    chk({tag, "_done_pulse"}, train_done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_ram"}, ram[{p, c}], exp_w);
  endtask

  // Starts a prediction and returns the number of sampling steps until pred_valid.
  task automatic start_pred(input logic [3:0] p, output int n);
    pred_prev = p; pred_req = 1'b1;
    #1;
    step();
    pred_req = 1'b0;
    n = 1;
    while (!pred_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic finish_pred();
    pred_ready = 1'b1;
    step();
    pred_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic ok;
    train_valid = 1'b0; train_prev = '0; train_cur = '0;
    pred_req = 1'b0; pred_prev = '0; pred_ready = 1'b0;
`ifdef MARKOV_CLEAR_EN
    clear_req = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ram[i] = '0;

    // Reset with both requests pending: nothing may leak out.
    train_prev = 4'h1; train_cur = 4'h1; train_valid = 1'b1;
    pred_prev = 4'h3; pred_req = 1'b1;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_train_ready", train_ready, 0);
    chk("rst_pred_ack", pred_ack, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_hit", pred_hit, 0);
    chk("rst_pred_cnt", pred_cnt, 0);

    // First contention after reset goes to TRAIN, then alternates.
    reset = 1'b1;
    pred_ready = 1'b1;
    #1;
    chk("cont0_train", train_ready, 1);
    chk("cont0_pred", pred_ack, 0);
    for (int k = 0; k < 4; k++) begin
      wait_idle("cont_wait");
      chk("cont_train", train_ready, (k % 2 == 1) ? 1 : 0);
      chk("cont_pred", pred_ack, (k % 2 == 0) ? 1 : 0);
    end
    step();
    train_valid = 1'b0; pred_req = 1'b0; pred_ready = 1'b0;
    wait_idle("cont_drain");
    chk("cont_ram11", ram[8'h11], 3);

    // Training: zero entry, then saturation.
    do_train("trn", 4'h3, 4'h5, 8'd1);
    ram[8'h35] = 8'd255;
    do_train("sat", 4'h3, 4'h5, 8'd255);

    // Prediction with a tie between symbols 7 and 9.
    ram[8'h35] = 8'd0; ram[8'h32] = 8'd4; ram[8'h37] = 8'd9; ram[8'h39] = 8'd9;
    pred_prev = 4'h3; pred_req = 1'b1;
    #1;
    chk("prd_ack", pred_ack, 1);
    step();
    pred_req = 1'b0;
    chk("prd_first_re", mem_re, 1);
    chk("prd_first_addr", mem_addr, 8'h30);
    n = 1;
    while (!pred_valid && n < 40) begin
      step();
      n++;
    end
    // NSYM+1 clock edges after the accept edge -> 18th sampling step.
    chk("prd_latency", n, 18);
    chk("prd_sym", pred_sym, 7);
    chk("prd_cnt", pred_cnt, 9);
    chk("prd_hit", pred_hit, 1);
    ok = 1'b1;
    repeat (5) begin
      step();
      if (pred_valid !== 1'b1 || pred_sym !== 4'h7 || pred_cnt !== 8'd9) ok = 1'b0;
    end
    chk("prd_hold", ok, 1);
    finish_pred();
    chk("prd_release_valid", pred_valid, 0);
    chk("prd_release_busy", busy, 0);

    // All-zero row.
    start_pred(4'h4, n);
    chk("zero_valid", pred_valid, 1);
    chk("zero_sym", pred_sym, 0);
    chk("zero_cnt", pred_cnt, 0);
    chk("zero_hit", pred_hit, 0);
    finish_pred();

    // Only the last symbol nonzero.
    ram[8'h5F] = 8'd3;
    start_pred(4'h5, n);
    chk("last_valid", pred_valid, 1);
    chk("last_sym", pred_sym, 4'hF);
    chk("last_cnt", pred_cnt, 3);
    chk("last_hit", pred_hit, 1);
    finish_pred();

    // Asynchronous reset in the middle of a scan.
    pred_prev = 4'h3; pred_req = 1'b1;
    #1;
    step();
    pred_req = 1'b0;
    repeat (5) step();
    chk("mid_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_mem_re", mem_re, 0);
    chk("mid_pred_valid", pred_valid, 0);
    chk("mid_pred_cnt", pred_cnt, 0);
    chk("mid_pred_hit", pred_hit, 0);
    step();
    reset = 1'b1;
    do_train("post", 4'h3, 4'h5, 8'd1);

`ifdef MARKOV_CLEAR_EN
    // Clear outranks a pending train; train follows.
    clear_req = 1'b1;
    train_prev = 4'h2; train_cur = 4'h2; train_valid = 1'b1;
    #1;
    chk("clr_blocks_train", train_ready, 0);
    step();
    clear_req = 1'b0;
    n = 0;
    ok = 1'b1;
    while (n < 300) begin
      if (!(mem_we === 1'b1 && mem_addr === n[7:0] && mem_wdata === 8'd0)) ok = 1'b0;
      n++;
      if (clear_done === 1'b1) break;
      step();
    end
    chk("clr_writes", n, 256);
    chk("clr_seq", ok, 1);
    step();
    chk("clr_done_pulse", clear_done, 0);
    chk("clr_then_train", train_ready, 1);
    ok = 1'b1;
    for (int i = 0; i < 256; i++) if (ram[i] !== 8'd0) ok = 1'b0;
    chk("clr_ram_zero", ok, 1);
    step();
    train_valid = 1'b0;
    wait_idle("clr_train_idle");
    chk("clr_train_ram", ram[8'h22], 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
